// File: rtl/write_post_buffer_pkg.sv
// Shared types for the write post buffer.
// Op codes, read-source select and FSM states.
package write_post_buffer_pkg;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_RSV  = 2'b10,
    OP_NOOP = 2'b11
  } op_e;

  localparam logic SRC_CACHE = 1'b0;
  localparam logic SRC_DIN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    FLUSH_DONE
  } state_e;

  function automatic logic op_is(
    input logic       vld,
    input logic [1:0] op,
    input op_e        code
  );
    return vld && (op == code);
  endfunction

endpackage

// File: rtl/write_post_buffer_if.sv
// Processor/cache bundle of the write post buffer.
// master drives ops and cache ready; slave is the buffer.
interface write_post_buffer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);

  logic                      op_valid;
  logic [1:0]                op;
  logic [ADDR_W-1:0]         op_addr;
  logic [DATA_W-1:0]         op_wdata;
  logic                      op_ready;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;
  logic                      cwr_valid;
  logic [ADDR_W-1:0]         cwr_addr;
  logic [DATA_W-1:0]         cwr_data;
  logic                      cwr_ready;
  logic                      flush_req;
  logic                      flush_done;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output op_valid, op, op_addr, op_wdata,
    output cwr_ready, flush_req,
    input  op_ready, fwd_hit, fwd_data,
    input  cwr_valid, cwr_addr, cwr_data,
    input  flush_done, count
  );

  modport slave (
    input  op_valid, op, op_addr, op_wdata,
    input  cwr_ready, flush_req,
    output op_ready, fwd_hit, fwd_data,
    output cwr_valid, cwr_addr, cwr_data,
    output flush_done, count
  );

endinterface

// File: rtl/write_post_buffer_fwd_match.sv
// Newest-first address match over the buffer entries.
// Age runs backwards from wr_ptr; later hits overwrite older ones.
module wpb_fwd_match #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DEPTH-1:0]  entry_vld,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0] key,
  output logic              hit,
  output logic [PTR_W-1:0]  idx
);

  logic [PTR_W-1:0] pos;

  // walk oldest to newest so the newest match is the last one kept
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      pos = wr_ptr - PTR_W'(k);
      if (entry_vld[pos] && (entry_addr[pos] == key)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/write_post_buffer.sv
// Posted-write FIFO in front of the cache write port.
// Reads keep priority; buffered data is forwarded to hitting reads.
module write_post_buffer
  import write_post_buffer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             rst,
  write_post_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nx;
  state_e            state;

  logic             rd_now;
  logic             wr_now;
  logic             push;
  logic             pop;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             cwr_vld;
  logic             rdy;

  assign rd_now = op_is(bus.op_valid, bus.op, OP_RD);
  assign wr_now = op_is(bus.op_valid, bus.op, OP_WR);

  assign rdy     = (cnt_q < CNT_W'(DEPTH)) && (state != FLUSH);
  assign cwr_vld = ((state == DRAIN) || (state == FLUSH))
                 && (cnt_q != '0);

  assign push = wr_now && rdy;
  assign pop  = cwr_vld && bus.cwr_ready;

  assign bus.op_ready   = rdy;
  assign bus.cwr_valid  = cwr_vld;
  assign bus.cwr_addr   = addr_q[rd_ptr];
  assign bus.cwr_data   = data_q[rd_ptr];
  assign bus.flush_done = (state == FLUSH_DONE);
  assign bus.count      = cnt_q;

  // occupancy after this edge
  always_comb begin
    cnt_nx = cnt_q;
    unique case (1'b1)
      (push && !pop): cnt_nx = cnt_q + CNT_W'(1);
      (pop && !push): cnt_nx = cnt_q - CNT_W'(1);
      default:        cnt_nx = cnt_q;
    endcase
  end

  // entry payload; validity is tracked separately so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.op_addr;
      data_q[wr_ptr] <= bus.op_wdata;
    end
  end

  // pointers, valid mask and count; reset discards all entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      cnt_q <= cnt_nx;
      if (push) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        vld_q[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        vld_q[rd_ptr]  <= 1'b0;
      end
    end
  end

  // drain/flush control; a pending handshake is never dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.flush_req)
            state <= FLUSH;
          else if ((cnt_nx != '0) && !rd_now)
            state <= DRAIN;
        end
        DRAIN: begin
          if (bus.flush_req)
            state <= FLUSH;
          else if (pop && ((cnt_nx == '0) || rd_now))
            state <= IDLE;
        end
        FLUSH: begin
          if (cnt_nx == '0)
            state <= FLUSH_DONE;
        end
        FLUSH_DONE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  wpb_fwd_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_match (
    .entry_addr (addr_q),
    .entry_vld  (vld_q),
    .wr_ptr     (wr_ptr),
    .key        (bus.op_addr),
    .hit        (hit),
    .idx        (hit_idx)
  );

  // DIN read source: newest buffered data for a hitting read
  always_comb begin
    bus.fwd_hit  = rd_now && hit;
    bus.fwd_data = '0;
    if (bus.fwd_hit)
      bus.fwd_data = data_q[hit_idx];
  end

endmodule

// File: tb/tb_write_post_buffer.sv
// Directed bench for write_post_buffer.
// Cache writes are scored against an expected queue by a monitor.
module tb_write_post_buffer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  write_post_buffer_if #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (D)
  ) bus ();

  write_post_buffer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  vecs = 0;
  int  miss = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.op_valid = 1'b1;
    bus.op       = 2'b01;
    bus.op_addr  = a;
    bus.op_wdata = d;
    cyc();
    bus.op_valid = 1'b0;
    bus.op       = 2'b11;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus.op_valid = 1'b1;
    bus.op       = 2'b00;
    bus.op_addr  = a;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back(wr_t'{a: a, d: d});
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while ((bus.count != 0 || exp_q.size() != 0) && n < 40) begin
      cyc();
      n++;
    end
    chk({nm, "_count"}, 64'(bus.count), 64'd0);
    chk({nm, "_sb"}, 64'(exp_q.size()), 64'd0);
  endtask

  // cache-port monitor: every handshake must match the next expected write
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.cwr_valid && bus.cwr_ready) begin
        vecs++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL cwr_unexpected: got %0h:%0h want none",
                   bus.cwr_addr, bus.cwr_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.cwr_addr !== e.a || bus.cwr_data !== e.d) begin
            miss++;
            $display("FAIL cwr_order: got %0h:%0h want %0h:%0h",
                     bus.cwr_addr, bus.cwr_data, e.a, e.d);
          end
        end
      end
      if (bus.count > 3'(D)) begin
        miss++;
        $display("FAIL count_max: got %0d want <= %0d", bus.count, D);
      end
    end
  end

  initial begin
    bus.op_valid  = 1'b0;
    bus.op        = 2'b11;
    bus.op_addr   = '0;
    bus.op_wdata  = '0;
    bus.cwr_ready = 1'b0;
    bus.flush_req = 1'b0;
    cyc();
    cyc();

    // reset state
    rd(8'h00);
    #1;
    chk("rst_op_ready", 64'(bus.op_ready), 64'd1);
    chk("rst_cwr_valid", 64'(bus.cwr_valid), 64'd0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
    chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    bus.op_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // reset mid-drain discards entries
    wr(8'h01, 32'h0000_0001);
    wr(8'h02, 32'h0000_0002);
    wr(8'h03, 32'h0000_0003);
    chk("mid_count", 64'(bus.count), 64'd3);
    chk("mid_cwr_valid", 64'(bus.cwr_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_cwr_valid", 64'(bus.cwr_valid), 64'd0);
    cyc();
    rst = 1'b0;
    bus.cwr_ready = 1'b1;
    repeat (4) cyc();
    chk("mid_after_count", 64'(bus.count), 64'd0);

    // fill and stall
    bus.cwr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      wr(8'hA0 + 8'(i), 32'hD0D0_0000 + 32'(i));
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_op_ready", 64'(bus.op_ready), 64'd0);
    wr(8'hA4, 32'hD0D0_0004);
    chk("fill_5th_dropped", 64'(bus.count), 64'd4);
    for (int i = 0; i < 4; i++)
      expect_wr(8'hA0 + 8'(i), 32'hD0D0_0000 + 32'(i));
    bus.cwr_ready = 1'b1;
    wait_empty("fill_drain");

    // forwarding, newest wins
    bus.cwr_ready = 1'b0;
    wr(8'h10, 32'h1111_1111);
    wr(8'h10, 32'h2222_2222);
    wr(8'h30, 32'h3333_3333);
    rd(8'h10);
    #1;
    chk("fwd_new_hit", 64'(bus.fwd_hit), 64'd1);
    chk("fwd_new_data", 64'(bus.fwd_data), 64'h2222_2222);
    bus.op_addr = 8'h30;
    #1;
    chk("fwd_30_data", 64'(bus.fwd_data), 64'h3333_3333);
    bus.op_addr = 8'h20;
    #1;
    chk("fwd_miss_hit", 64'(bus.fwd_hit), 64'd0);
    chk("fwd_miss_data", 64'(bus.fwd_data), 64'd0);
    bus.op_valid = 1'b0;
    expect_wr(8'h10, 32'h1111_1111);
    expect_wr(8'h10, 32'h2222_2222);
    expect_wr(8'h30, 32'h3333_3333);
    bus.cwr_ready = 1'b1;
    wait_empty("fwd_drain");

    // read priority
    bus.cwr_ready = 1'b0;
    wr(8'h40, 32'h4040_4040);
    wr(8'h41, 32'h4141_4141);
    wr(8'h42, 32'h4242_4242);
    expect_wr(8'h40, 32'h4040_4040);
    expect_wr(8'h41, 32'h4141_4141);
    expect_wr(8'h42, 32'h4242_4242);
    rd(8'h41);
    bus.cwr_ready = 1'b1;
    cyc();
    chk("prio_yield_count", 64'(bus.count), 64'd2);
    repeat (3) begin
      chk("prio_no_cwr", 64'(bus.cwr_valid), 64'd0);
      cyc();
    end
    chk("prio_hold_count", 64'(bus.count), 64'd2);
    chk("prio_fwd_data", 64'(bus.fwd_data), 64'h4141_4141);
    bus.op_valid = 1'b0;
    cyc();
    chk("prio_drain_cwr", 64'(bus.cwr_valid), 64'd1);
    rd(8'h41);
    cyc();
    chk("prio_rd_count", 64'(bus.count), 64'd1);
    chk("prio_rd_idle", 64'(bus.cwr_valid), 64'd0);
    bus.op_valid = 1'b0;
    wait_empty("prio_drain");

    // wrap-around with concurrent pops
    bus.cwr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_wr(8'h80 + 8'(i), 32'hC000_0000 + 32'(i * 3));
      wr(8'h80 + 8'(i), 32'hC000_0000 + 32'(i * 3));
    end
    wait_empty("wrap");

    // flush with three entries
    bus.cwr_ready = 1'b0;
    wr(8'h50, 32'h5050_5050);
    wr(8'h51, 32'h5151_5151);
    wr(8'h52, 32'h5252_5252);
    rd(8'h51);
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    chk("fl_op_ready", 64'(bus.op_ready), 64'd0);
    chk("fl_fwd_data", 64'(bus.fwd_data), 64'h5151_5151);
    expect_wr(8'h50, 32'h5050_5050);
    expect_wr(8'h51, 32'h5151_5151);
    expect_wr(8'h52, 32'h5252_5252);
    bus.op       = 2'b01;
    bus.op_addr  = 8'h77;
    bus.op_wdata = 32'h7777_7777;
    bus.cwr_ready = 1'b1;
    cyc();
    chk("fl_pop1_count", 64'(bus.count), 64'd2);
    chk("fl_pop1_done", 64'(bus.flush_done), 64'd0);
    cyc();
    chk("fl_pop2_count", 64'(bus.count), 64'd1);
    cyc();
    chk("fl_pop3_count", 64'(bus.count), 64'd0);
    chk("fl_done_pulse", 64'(bus.flush_done), 64'd1);
    bus.op_valid = 1'b0;
    cyc();
    chk("fl_done_end", 64'(bus.flush_done), 64'd0);
    chk("fl_wr_blocked", 64'(bus.count), 64'd0);
    chk("fl_op_ready_back", 64'(bus.op_ready), 64'd1);

    // flush on empty buffer
    bus.flush_req = 1'b1;
    cyc();
    bus.flush_req = 1'b0;
    chk("fe_c1_done", 64'(bus.flush_done), 64'd0);
    cyc();
    chk("fe_c2_done", 64'(bus.flush_done), 64'd1);
    cyc();
    chk("fe_c3_done", 64'(bus.flush_done), 64'd0);

    chk("sb_final", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
